// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU; 1-cycle issue latency,
// response held until rsp_ready, no new accept while a response is outstanding.
module alu_arbiter #(
  parameter logic [3:0] DIV_OP = 4'b0011,
  parameter logic [3:0] MAX_OP = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_s,
  input  logic       alu_z,
  input  logic       alu_p,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_s,
  output logic       rsp_z,
  output logic       rsp_p,
  output logic       rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant;
  logic       accept;
  logic [7:0] lat_a, lat_b;
  logic [3:0] lat_op;
  logic       lat_id;

  logic [7:0] nxt_result;
  logic       nxt_carry, nxt_s, nxt_z, nxt_p, nxt_err;

  // With both pending, the requester not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = RESP;
      RESP:  if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = rst_n & accept & ~grant;
  assign req1_ready = rst_n & accept & grant;

  // Latched operands only change on accept, so they already hold outside ISSUE.
  assign alu_a  = lat_a;
  assign alu_b  = lat_b;
  assign alu_op = lat_op;

  always_comb begin
    nxt_result = alu_result;
    nxt_carry  = alu_carry;
    nxt_s      = alu_s;
    nxt_z      = alu_z;
    nxt_p      = alu_p;
    nxt_err    = 1'b0;
    if (lat_op > MAX_OP) begin
      nxt_result = 8'h00;
      nxt_carry  = 1'b0;
      nxt_s      = 1'b0;
      nxt_z      = 1'b1;
      nxt_p      = 1'b1;
      nxt_err    = 1'b1;
    end else if (lat_op == DIV_OP && lat_b == 8'h00) begin
      nxt_result = 8'hFF;
      nxt_carry  = 1'b0;
      nxt_s      = 1'b1;
      nxt_z      = 1'b0;
      nxt_p      = 1'b1;
      nxt_err    = 1'b1;
    end else if (lat_op >= 4'd4) begin
      // Logic and shift ops leave the ALU carry undefined.
      nxt_carry  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_a      <= 8'h00;
      lat_b      <= 8'h00;
      lat_op     <= 4'h0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_s      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_p      <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        last_grant <= grant;
        lat_id     <= grant;
        lat_a      <= grant ? req1_a  : req0_a;
        lat_b      <= grant ? req1_b  : req0_b;
        lat_op     <= grant ? req1_op : req0_op;
      end
      if (state == ISSUE) begin
        rsp_id     <= lat_id;
        rsp_result <= nxt_result;
        rsp_carry  <= nxt_carry;
        rsp_s      <= nxt_s;
        rsp_z      <= nxt_z;
        rsp_p      <= nxt_p;
        rsp_err    <= nxt_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: plays the shared ALU and both requesters, scoreboards responses.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  logic       alu_carry, alu_s, alu_z, alu_p;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_s(alu_s), .alu_z(alu_z), .alu_p(alu_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_s(rsp_s), .rsp_z(rsp_z), .rsp_p(rsp_p), .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       c, s, z, p, err;
  } rsp_t;

  // Reference ALU; carry is deliberately 1 for ops 4..9 so forcing is observable.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [8:0]  r9;
    logic [15:0] m;
    logic [7:0]  r;
    logic        c;
    r9 = 9'h0; m = 16'h0; r = 8'h5A; c = 1'b1;
    case (op)
      4'd0: begin r9 = {1'b0, a} + {1'b0, b}; r = r9[7:0]; c = r9[8]; end
      4'd1: begin r9 = {1'b0, a} - {1'b0, b}; r = r9[7:0]; c = r9[8]; end
      4'd2: begin m = a * b; r = m[7:0]; c = |m[15:8]; end
      4'd3: begin r = (b == 8'h00) ? 8'hAA : a / b; c = 1'b0; end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = ~a;
      4'd7: r = a ^ b;
      4'd8: r = a << b[2:0];
      4'd9: r = a >> b[2:0];
      default: r = 8'h5A;
    endcase
    return {c, r[7], (r == 8'h00), ~^r, r};
  endfunction

  assign {alu_carry, alu_s, alu_z, alu_p, alu_result} = alu_model(alu_a, alu_b, alu_op);

  function automatic rsp_t exp_of(input logic id, input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] op);
    rsp_t e;
    e.id = id;
    e.err = 1'b0;
    if (op > 4'd9) begin
      e.res = 8'h00; e.c = 1'b0; e.s = 1'b0; e.z = 1'b1; e.p = 1'b1; e.err = 1'b1;
    end else if (op == 4'd3 && b == 8'h00) begin
      e.res = 8'hFF; e.c = 1'b0; e.s = 1'b1; e.z = 1'b0; e.p = 1'b1; e.err = 1'b1;
    end else begin
      {e.c, e.s, e.z, e.p, e.res} = alu_model(a, b, op);
      if (op >= 4'd4) e.c = 1'b0;
    end
    return e;
  endfunction

  rsp_t q[$];
  rsp_t cur, prev_snap, last_got, e;
  int   total = 0, bad = 0, cyc = 0;
  int   acc_id, last_id, prev_acc_cyc, n_rr;
  bit   s_rsp_vld, s_hs, oneshot, rr_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge+1, then advance to the next negedge.
  task automatic step();
    bit hs;
    #1;
    cyc++;
    acc_id = -1;
    cur = {rsp_id, rsp_result, rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err};
    chk("ready_mutex", 32'(req0_ready & req1_ready), 32'd0);
    if (req0_ready || req1_ready) begin
      acc_id = req1_ready ? 1 : 0;
      if (req0_valid && req1_valid) chk("rr_grant", acc_id, (last_id == 0) ? 1 : 0);
      if (rr_mode) begin
        if (prev_acc_cyc >= 0) chk("rr_interval", cyc - prev_acc_cyc, 3);
        n_rr++;
      end
      if (acc_id == 1) q.push_back(exp_of(1'b1, req1_a, req1_b, req1_op));
      else             q.push_back(exp_of(1'b0, req0_a, req0_b, req0_op));
      last_id = acc_id;
      prev_acc_cyc = cyc;
    end
    if (rsp_valid && !s_rsp_vld) chk("rsp_latency", cyc - prev_acc_cyc, 2);
    if (rsp_valid && s_rsp_vld && !s_hs) chk("rsp_stable", 32'(cur), 32'(prev_snap));
    hs = rsp_valid && rsp_ready;
    if (hs) begin
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=response expected=none");
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_fields", 32'(cur), 32'(e));
        last_got = cur;
      end
    end
    s_rsp_vld = rsp_valid;
    s_hs = hs;
    prev_snap = cur;
    @(negedge clk);
    if (oneshot && acc_id == 0) req0_valid = 1'b0;
    if (oneshot && acc_id == 1) req1_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((req0_valid || req1_valid || q.size() > 0 || s_rsp_vld) && n < max) begin
      step();
      n++;
    end
    total++;
    assert (n < max) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d expected<%0d", n, max);
    end
  endtask

  task automatic wait_vld(input int max);
    int n = 0;
    do begin step(); n++; end while (!s_rsp_vld && n < max);
    chk("wait_rsp_valid", 32'(s_rsp_vld), 32'd1);
  endtask

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op);
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 8'h0; req0_b = 8'h0; req0_op = 4'h0;
    req1_a = 8'h0; req1_b = 8'h0; req1_op = 4'h0;
    last_id = 1; prev_acc_cyc = -1; n_rr = 0;
    s_rsp_vld = 0; s_hs = 0; oneshot = 1; rr_mode = 0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_regs", 32'({rsp_id, rsp_result, rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err}), 32'd0);
    chk("rst_alu_regs", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("rst_readys", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk); @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // ADD with carry out
    issue(0, 8'hF0, 8'h20, 4'd0);
    drain(20);
    chk("add_rsp", 32'(last_got), 32'({1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

    // divide by zero from requester 1
    issue(1, 8'h10, 8'h00, 4'd3);
    drain(20);
    chk("div0_rsp", 32'(last_got), 32'({1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));

    // illegal opcode, then XOR to zero
    issue(0, 8'h33, 8'h44, 4'hF);
    drain(20);
    chk("illegal_rsp", 32'(last_got), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}));
    issue(0, 8'h0F, 8'h0F, 4'd7);
    drain(20);
    chk("xor_rsp", 32'(last_got), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));

    // mixed ops from alternating requesters, scoreboarded
    for (int i = 0; i < 12; i++) begin
      issue(i % 2, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 4'(i));
      drain(20);
    end
    issue(1, 8'h81, 8'h07, 4'd1);
    drain(20);
    issue(0, 8'h9C, 8'h00, 4'd3);
    drain(20);

    // both requesters continuously valid
    oneshot = 0; rr_mode = 1; prev_acc_cyc = -1; n_rr = 0;
    issue(0, 8'hC3, 8'h5A, 4'd4);
    issue(1, 8'h12, 8'h34, 4'd2);
    for (int i = 0; i < 14; i++) step();
    chk("rr_accepts", n_rr, 5);
    rr_mode = 0; oneshot = 1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(20);

    // response back-pressure with req1 waiting
    rsp_ready = 1'b0;
    issue(0, 8'h01, 8'h02, 4'd0);
    wait_vld(10);
    issue(1, 8'h05, 8'h03, 4'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_no_accept", acc_id, -1);
    end
    rsp_ready = 1'b1;
    step();
    chk("hs_no_accept", acc_id, -1);
    step();
    chk("accept_after_hs", acc_id, 1);
    drain(20);

    // reset while a response is pending
    rsp_ready = 1'b0;
    issue(1, 8'h22, 8'h11, 4'd5);
    wait_vld(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_regs", 32'({rsp_result, alu_op, rsp_id}), 32'd0);
    q.delete();
    last_id = 1; prev_acc_cyc = -1; s_rsp_vld = 0; s_hs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    issue(0, 8'h40, 8'h02, 4'd8);
    issue(1, 8'h40, 8'h02, 4'd9);
    step();
    chk("post_rst_grant", acc_id, 0);
    drain(30);

    chk("sb_leftover", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
